// File: rtl/eq_band_mixer.sv
// Multi-channel band equaliser/mixer: per-band gain sum through one shared multiplier, then master volume.
// Define EQ_MIX_CLIP_CNT_EN to add the clip_cnt saturation counter output.
module eq_band_mixer #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned NUM_BANDS = 5,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GAIN_W    = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_CH*NUM_BANDS*DATA_W-1:0] band_in,
  input  logic [NUM_BANDS*GAIN_W-1:0]        band_gain,
  input  logic [GAIN_W-1:0]                  volume,
  output logic                               out_valid,
  output logic [NUM_CH*DATA_W-1:0]           audio_out
`ifdef EQ_MIX_CLIP_CNT_EN
  ,
  output logic [7:0]                         clip_cnt
`endif
);

  localparam int unsigned IN_W   = NUM_CH * NUM_BANDS * DATA_W;
  localparam int unsigned BG_W   = NUM_BANDS * GAIN_W;
  localparam int unsigned OUT_W  = NUM_CH * DATA_W;
  localparam int unsigned ACC_W  = DATA_W + GAIN_W + $clog2(NUM_BANDS) + 1;
  localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'($signed({1'b0, {(DATA_W-1){1'b1}}}));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'($signed({1'b1, {(DATA_W-1){1'b0}}}));

  typedef enum logic [1:0] {IDLE, ACCUM, VOL, DONE} state_t;

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return x[DATA_W-1:0];
  endfunction

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [BAND_W-1:0]         band_q, band_d;
  logic [IN_W-1:0]           samp_q, samp_d;
  logic [BG_W-1:0]           gain_q, gain_d;
  logic [GAIN_W-1:0]         vol_q, vol_d;
  logic [OUT_W-1:0]          shadow_q, shadow_d;
  logic [OUT_W-1:0]          audio_q, audio_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic signed [DATA_W-1:0]  mul_a;
  logic [GAIN_W-1:0]         mul_b;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   term;
  logic signed [DATA_W-1:0]  acc_sat;
  logic signed [DATA_W-1:0]  vol_sat;
  logic [31:0]               samp_idx;
  logic [31:0]               gain_idx;

  // Datapath around the single multiplier, plus next-state logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    band_d      = band_q;
    samp_d      = samp_q;
    gain_d      = gain_q;
    vol_d       = vol_q;
    shadow_d    = shadow_q;
    audio_d     = audio_q;

    samp_idx = (32'(ch_q) * NUM_BANDS + 32'(band_q)) * DATA_W;
    gain_idx = 32'(band_q) * GAIN_W;
    acc_sat  = sat_fn(acc_q);

    // VOL reuses the band multiplier for the master-volume product
    if (state_q == VOL) begin
      mul_a = acc_sat;
      mul_b = vol_q;
    end else begin
      mul_a = DATA_W'(samp_q >> samp_idx);
      mul_b = GAIN_W'(gain_q >> gain_idx);
    end
    prod    = PROD_W'(mul_a) * PROD_W'($signed({1'b0, mul_b}));
    term    = ACC_W'(prod >>> (GAIN_W - 1));
    vol_sat = sat_fn(term);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          samp_d  = band_in;
          gain_d  = band_gain;
          vol_d   = volume;
          acc_d   = '0;
          ch_d    = '0;
          band_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        if (band_q == BAND_W'(NUM_BANDS - 1)) state_d = VOL;
        else                                  band_d  = band_q + BAND_W'(1);
      end
      VOL: begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (ch_q == CH_W'(c)) shadow_d[c*DATA_W +: DATA_W] = vol_sat;
        end
        acc_d  = '0;
        band_d = '0;
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = DONE;
          audio_d = shadow_d;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ACCUM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ch_q        <= '0;
      band_q      <= '0;
      samp_q      <= '0;
      gain_q      <= '0;
      vol_q       <= '0;
      shadow_q    <= '0;
      audio_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      band_q      <= band_d;
      samp_q      <= samp_d;
      gain_q      <= gain_d;
      vol_q       <= vol_d;
      shadow_q    <= shadow_d;
      audio_q     <= audio_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign audio_out = audio_q;

`ifdef EQ_MIX_CLIP_CNT_EN
  function automatic logic clip_fn(input logic signed [ACC_W-1:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  logic [3:0] frame_clips_q, frame_clips_d;
  logic [7:0] clip_cnt_q, clip_cnt_d;
  logic [8:0] clip_sum;

  // At most one clip per channel per frame; frame total folded in on DONE entry
  always_comb begin
    frame_clips_d = frame_clips_q;
    clip_cnt_d    = clip_cnt_q;
    clip_sum      = '0;
    if (state_q == IDLE && in_valid) frame_clips_d = '0;
    if (state_q == VOL) begin
      if (clip_fn(acc_q) || clip_fn(term)) frame_clips_d = frame_clips_q + 4'd1;
      if (ch_q == CH_W'(NUM_CH - 1)) begin
        clip_sum   = 9'(clip_cnt_q) + 9'(frame_clips_d);
        clip_cnt_d = (clip_sum > 9'd255) ? 8'd255 : clip_sum[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_clips_q <= '0;
      clip_cnt_q    <= '0;
    end else begin
      frame_clips_q <= frame_clips_d;
      clip_cnt_q    <= clip_cnt_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`endif

endmodule
